fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC loaded on reset.
REQ-002 Port i_clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port i_reset  in  1  reset; one clock; synchronous, active-high.
REQ-004 Port i_stall  in  1  decode cannot accept o_inst this cycle.
REQ-005 Port i_redirect  in  1  single-cycle redirect request from execute.
REQ-006 Port i_redirectJalr  in  1  0 = PC-relative (pc+imm), 1 = register-based (reg+imm).
REQ-007 Port i_redirectPc / i_redirectImm / i_redirectReg  in  InstAddr / Data / Data  redirect operands.
REQ-008 Port o_aluOp  out  2  operation to shared branch ALU: 00 pc+4, 01 pc+imm, 11 reg+imm.
REQ-009 Port o_aluPc / o_aluImm / o_aluReg  out  InstAddr / Data / Data  branch ALU operands.
REQ-010 Port i_aluResult  in  InstAddr  combinational branch ALU result, same cycle.
REQ-011 Port o_ibusAddr / o_ibusRd  out  InstAddr / 1  instruction bus read request.
REQ-012 Port i_ibusAck / i_ibusData  in  1 / 32  bus completion and read data, same cycle.
REQ-013 Port o_inst / o_instPc / o_instValid  out  32 / InstAddr / 1  registered fetched instruction to decode.

Function
REQ-014 States: START, FETCH, HOLD, DRAIN; internal registers pc, state.
REQ-015 ALU drive: i_redirect=1 -> o_aluOp={i_redirectJalr,1}, operands from redirect ports; else op 00, o_aluPc=pc, o_aluImm=o_aluReg=0.
REQ-016 START: no bus request; next cycle FETCH.
REQ-017 FETCH: o_ibusRd=1, o_ibusAddr=pc; ack without redirect -> o_inst<=i_ibusData, o_instPc<=pc, o_instValid<=1, pc<=i_aluResult (pc+4).
REQ-018 Output slot rule: fetch issued only when !o_instValid or !i_stall; otherwise state HOLD, o_ibusRd=0, o_inst* held.
REQ-019 HOLD -> FETCH in the cycle after i_stall deasserts; o_instValid cleared when consumed with no new data.
REQ-020 Bus rule: once o_ibusRd asserted, o_ibusAddr and o_ibusRd stay stable until i_ibusAck.
REQ-021 Redirect: pc<=i_aluResult (bit0 cleared when Jalr); o_instValid<=0 next cycle (flush), regardless of i_stall.
REQ-022 Redirect in FETCH without ack -> DRAIN: keep requesting old address until ack, discard data, then FETCH at new pc.
REQ-023 Redirect with ack in the same cycle: data discarded, pc<=target, stay FETCH.
REQ-024 Redirect in DRAIN: target overwritten (latest wins); remain DRAIN until ack.
REQ-025 Redirect in HOLD/START: pc<=target, next state FETCH.
REQ-026 Latency: ack at cycle N -> o_instValid=1 at N+1; next request at N+1 if slot free; redirect at N with no outstanding request -> request to target at N+1.
REQ-027 Arithmetic: InstAddr-wide, modulo 2^width; pc 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-028 On i_reset: state=START, pc=RESET_PC, o_instValid=0, o_inst=0, o_instPc=0, o_ibusRd=0.
REQ-029 Reset has priority over redirect and ack; reset mid-request abandons it, data of a later ack ignored (START issues nothing).
REQ-030 First request after reset: cycle 2 after reset deassertion, o_ibusAddr=RESET_PC.

Verification
REQ-031 Reset release, ack every cycle, no stall -> addresses 0,4,8,...; o_instPc lags o_ibusAddr by one cycle.
REQ-032 i_stall held 3 cycles with o_instValid=1 -> o_ibusRd=0, o_inst stable; fetch resumes one cycle after release.
REQ-033 Redirect Jalr=0, pc=0x100, imm=0x20, no outstanding request -> o_aluOp=01, next o_ibusAddr=0x120, o_instValid=0.
REQ-034 Redirect Jalr=1, reg=0x2003, imm=0 while request to 0x40 pending, ack 2 cycles later -> 0x40 held until ack, data discarded, next address 0x2002.
REQ-035 pc=0xFFFF_FFFC acked -> next address 0x0000_0000.
REQ-036 i_reset asserted during pending request -> outputs at reset values next cycle; later ack ignored; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC over the instruction bus, holds one fetched
// instruction for decode, and handles redirects from execute through a shared branch ALU.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic        i_redirectJalr,
    input  logic [31:0] i_redirectPc,
    input  logic [31:0] i_redirectImm,
    input  logic [31:0] i_redirectReg,
    output logic [1:0]  o_aluOp,
    output logic [31:0] o_aluPc,
    output logic [31:0] o_aluImm,
    output logic [31:0] o_aluReg,
    input  logic [31:0] i_aluResult,
    output logic [31:0] o_ibusAddr,
    output logic        o_ibusRd,
    input  logic        i_ibusAck,
    input  logic [31:0] i_ibusData,
    output logic [31:0] o_inst,
    output logic [31:0] o_instPc,
    output logic        o_instValid
);

    typedef enum logic [1:0] {StStart, StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        slot_free;
    logic [31:0] redirect_target;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= StStart;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        if (i_redirect) begin
            o_aluOp  = {i_redirectJalr, 1'b1};
            o_aluPc  = i_redirectPc;
            o_aluImm = i_redirectImm;
            o_aluReg = i_redirectReg;
        end else begin
            o_aluOp  = 2'b00;
            o_aluPc  = pc_q;
            o_aluImm = 32'h0;
            o_aluReg = 32'h0;
        end
    end

    assign redirect_target = i_redirectJalr ? {i_aluResult[31:1], 1'b0} : i_aluResult;
    assign slot_free       = !inst_valid_q || !i_stall;

    always_comb begin
        o_ibusRd   = 1'b0;
        o_ibusAddr = pc_q;
        unique case (state_q)
            StStart: ;
            StFetch: o_ibusRd = slot_free;
            StHold:  ;
            // The abandoned request must stay on the bus until it completes.
            StDrain: begin
                o_ibusRd   = 1'b1;
                o_ibusAddr = drain_addr_q;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        // Decode consumes the held instruction whenever it is not stalling.
        inst_valid_d = inst_valid_q && i_stall;

        unique case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (!o_ibusRd) begin
                    state_d = StHold;
                end else if (i_ibusAck && !i_redirect) begin
                    inst_d       = i_ibusData;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = i_aluResult;
                end
            end
            StHold: begin
                if (!i_stall) state_d = StFetch;
            end
            StDrain: begin
                if (i_ibusAck) state_d = StFetch;
            end
        endcase

        if (i_redirect) begin
            pc_d         = redirect_target;
            inst_valid_d = 1'b0;
            if (state_q != StDrain) begin
                if (o_ibusRd && !i_ibusAck) begin
                    state_d      = StDrain;
                    drain_addr_d = pc_q;
                end else begin
                    state_d = StFetch;
                end
            end
        end
    end

    assign o_inst      = inst_q;
    assign o_instPc    = inst_pc_q;
    assign o_instValid = inst_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random stall/ack/redirect/reset
// traffic, with a scoreboard tracking the instruction stream decode should receive.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic        redirect_jalr;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_imm;
    logic [31:0] redirect_reg;
    logic [1:0]  alu_op;
    logic [31:0] alu_pc;
    logic [31:0] alu_imm;
    logic [31:0] alu_reg;
    logic [31:0] alu_result;
    logic [31:0] ibus_addr;
    logic        ibus_rd;
    logic        ibus_ack;
    logic [31:0] ibus_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    logic        ack_en;
    logic        ack_force;
    logic        mon_en;
    int          tests;
    int          failures;
    int          consumed;
    logic [31:0] redir_q[$];

    fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_stall        (stall),
        .i_redirect     (redirect),
        .i_redirectJalr (redirect_jalr),
        .i_redirectPc   (redirect_pc),
        .i_redirectImm  (redirect_imm),
        .i_redirectReg  (redirect_reg),
        .o_aluOp        (alu_op),
        .o_aluPc        (alu_pc),
        .o_aluImm       (alu_imm),
        .o_aluReg       (alu_reg),
        .i_aluResult    (alu_result),
        .o_ibusAddr     (ibus_addr),
        .o_ibusRd       (ibus_rd),
        .i_ibusAck      (ibus_ack),
        .i_ibusData     (ibus_data),
        .o_inst         (inst),
        .o_instPc       (inst_pc),
        .o_instValid    (inst_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Shared branch ALU and instruction memory seen by the DUT.
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_pc + 32'd4;
            2'b01:   alu_result = alu_pc + alu_imm;
            2'b11:   alu_result = alu_reg + alu_imm;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    assign ibus_ack  = (ibus_rd && ack_en) || ack_force;
    assign ibus_data = mem_word(ibus_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_redirect(input logic jalr, input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] rg);
        logic [31:0] tgt;
        redirect      = 1'b1;
        redirect_jalr = jalr;
        redirect_pc   = pc;
        redirect_imm  = imm;
        redirect_reg  = rg;
        tgt = jalr ? ((rg + imm) & ~32'd1) : (pc + imm);
        redir_q.push_back(tgt);
    endtask

    // Monitor: protocol checks plus in-order scoreboard of instructions handed to decode.
    initial begin
        logic [31:0] exp_pc;
        logic        prev_rd, prev_ack, prev_reset, prev_redirect;
        logic [31:0] prev_addr;
        exp_pc        = RESET_PC;
        prev_rd       = 1'b0;
        prev_ack      = 1'b0;
        prev_reset    = 1'b0;
        prev_redirect = 1'b0;
        prev_addr     = 32'h0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_rd && !prev_ack && !prev_reset) begin
                    check("bus_rd_held", 32'(ibus_rd), 32'd1);
                    check("bus_addr_held", ibus_addr, prev_addr);
                end
                if (prev_redirect && !prev_reset) check("flush_after_redirect", 32'(inst_valid), 0);
                if (redirect) begin
                    check("alu_op_redirect", 32'(alu_op), {30'd0, redirect_jalr, 1'b1});
                    check("alu_pc_redirect", alu_pc, redirect_pc);
                    check("alu_reg_redirect", alu_reg, redirect_reg);
                end else begin
                    check("alu_op_seq", 32'(alu_op), 32'd0);
                    check("alu_imm_seq", alu_imm, 32'd0);
                    check("alu_reg_seq", alu_reg, 32'd0);
                end
                if (rst) begin
                    exp_pc = RESET_PC;
                end else begin
                    if (inst_valid && !stall) begin
                        check("consumed_pc", inst_pc, exp_pc);
                        check("consumed_inst", inst, mem_word(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        consumed++;
                    end
                    if (redirect) begin
                        check("redirect_queued", 32'(redir_q.size() != 0), 32'd1);
                        if (redir_q.size() != 0) exp_pc = redir_q.pop_front();
                    end
                end
                prev_rd       = ibus_rd;
                prev_ack      = ibus_ack;
                prev_addr     = ibus_addr;
                prev_reset    = rst;
                prev_redirect = redirect;
            end
        end
    end

    initial begin
        tests = 0; failures = 0; consumed = 0; mon_en = 1'b0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_jalr = 1'b0;
        redirect_pc = 32'h0; redirect_imm = 32'h0; redirect_reg = 32'h0;
        ack_en = 1'b0; ack_force = 1'b0;

        tick(); mon_en = 1'b1;
        tick(); #2;
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_rd", 32'(ibus_rd), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        rst = 1'b0; ack_en = 1'b1; #1;
        check("start_no_request", 32'(ibus_rd), 0);

        // Sequential fetch with an ack every cycle.
        for (int k = 0; k < 6; k++) begin
            tick(); #2;
            check("seq_rd", 32'(ibus_rd), 1);
            check("seq_addr", ibus_addr, 32'(4 * k));
            if (k > 0) begin
                check("seq_inst_pc", inst_pc, 32'(4 * (k - 1)));
                check("seq_valid", 32'(inst_valid), 1);
            end
        end

        // Stall for three cycles with an instruction held.
        tick(); stall = 1'b1; #2;
        check("stall_rd", 32'(ibus_rd), 0);
        check("stall_inst", inst, mem_word(32'd20));
        check("stall_inst_pc", inst_pc, 32'd20);
        for (int k = 0; k < 2; k++) begin
            tick(); #2;
            check("hold_rd", 32'(ibus_rd), 0);
            check("hold_inst", inst, mem_word(32'd20));
            check("hold_valid", 32'(inst_valid), 1);
        end
        tick(); stall = 1'b0; #2;
        check("release_no_fetch", 32'(ibus_rd), 0);
        tick(); #2;
        check("resume_rd", 32'(ibus_rd), 1);
        check("resume_addr", ibus_addr, 32'd24);
        check("resume_valid", 32'(inst_valid), 0);

        // PC-relative redirect coinciding with an ack.
        tick(); drive_redirect(1'b0, 32'h100, 32'h20, 32'h0); #2;
        check("rel_alu_op", 32'(alu_op), 32'd1);
        tick(); drive_redirect(1'b0, 32'h40, 32'h0, 32'h0); #2;
        check("rel_valid", 32'(inst_valid), 0);
        check("rel_rd", 32'(ibus_rd), 1);
        check("rel_addr", ibus_addr, 32'h120);

        // Register redirect while the request to 0x40 is outstanding.
        tick(); ack_en = 1'b0; drive_redirect(1'b1, 32'h0, 32'h0, 32'h2003); #2;
        check("jalr_addr", ibus_addr, 32'h40);
        check("jalr_alu_op", 32'(alu_op), 32'd3);
        tick(); redirect = 1'b0; #2;
        check("drain_rd", 32'(ibus_rd), 1);
        check("drain_addr", ibus_addr, 32'h40);
        check("drain_valid", 32'(inst_valid), 0);
        tick(); ack_en = 1'b1; #2;
        check("drain_addr_ack", ibus_addr, 32'h40);
        tick(); drive_redirect(1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0); #2;
        check("after_drain_addr", ibus_addr, 32'h2002);
        check("after_drain_valid", 32'(inst_valid), 0);

        // Address wrap.
        tick(); redirect = 1'b0; #2;
        check("wrap_top_addr", ibus_addr, 32'hFFFF_FFFC);
        tick(); ack_en = 1'b0; #2;
        check("wrap_addr", ibus_addr, 32'h0);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst", inst, mem_word(32'hFFFF_FFFC));

        // Reset during a pending request; a late ack must be ignored.
        tick(); rst = 1'b1; #2;
        check("pending_rd", 32'(ibus_rd), 1);
        tick(); rst = 1'b0; ack_force = 1'b1; #2;
        check("midreq_rst_valid", 32'(inst_valid), 0);
        check("midreq_rst_rd", 32'(ibus_rd), 0);
        check("midreq_rst_inst", inst, 0);
        check("midreq_rst_inst_pc", inst_pc, 0);
        tick(); ack_force = 1'b0; #2;
        check("restart_rd", 32'(ibus_rd), 1);
        check("restart_addr", ibus_addr, RESET_PC);
        check("restart_valid", 32'(inst_valid), 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            stall    = ($urandom_range(0, 9) < 3);
            ack_en   = ($urandom_range(0, 9) < 6);
            rst      = ($urandom_range(0, 499) == 0);
            redirect = 1'b0;
            if (!rst && $urandom_range(0, 19) == 0) begin
                drive_redirect(1'($urandom_range(0, 1)), $urandom & ~32'd3,
                               32'($urandom_range(0, 1023)) << 2, $urandom);
            end
        end
        tick();
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("progress", 32'(consumed > 300), 32'd1);
        check("redirects_drained", 32'(redir_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
